prbs7_checker: RTL

//  Receive-end counterpart of PRBS7: checks a deserialized PRBS7 word stream (x^7+x^6+1, LSB = earliest bit).

---
 rtl/prbs7_checker.sv | 126 ++++++++++++
 1 files changed

// File: rtl/prbs7_checker.sv
// Self-synchronizing PRBS7 (x^7+x^6+1) word checker with lock FSM and
// saturating error counter; din[0] is the earliest received bit.
module prbs7_checker #(
  parameter int WORDWIDTH  = 32,
  parameter int LOCK_GOOD  = 8,
  parameter int UNLOCK_BAD = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WORDWIDTH-1:0] din,
  input  logic                 din_valid,
  input  logic                 clear,
  output logic                 locked,
  output logic                 err,
  output logic [CNT_WIDTH-1:0] errorCount
);

  localparam int NW = $clog2(WORDWIDTH + 1);
  localparam int GW = $clog2(LOCK_GOOD + 1);
  localparam int BW = $clog2(UNLOCK_BAD + 1);
  localparam int SW = ((CNT_WIDTH > NW) ? CNT_WIDTH : NW) + 1;

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t               state, state_nxt;
  logic [6:0]           hist7;
  logic                 hist_valid;
  logic [GW-1:0]        good_run, good_run_nxt;
  logic [BW-1:0]        bad_run, bad_run_nxt;
  logic [CNT_WIDTH-1:0] cnt_nxt;
  logic                 err_nxt;

  logic [WORDWIDTH+6:0] s;
  logic [WORDWIDTH-1:0] e;
  logic [NW-1:0]        nerr;
  logic [SW-1:0]        sum;
  logic                 check;
  logic                 bad;

  // Each bit is predicted from the received bits 6 and 7 positions earlier.
  always_comb begin
    s    = {din, hist7};
    e    = '0;
    nerr = '0;
    for (int unsigned i = 0; i < WORDWIDTH; i++) begin
      e[i] = s[i+7] ^ s[i+1] ^ s[i];
    end
    for (int unsigned i = 0; i < WORDWIDTH; i++) begin
      nerr = nerr + NW'(e[i]);
    end
    // All-zero input satisfies the recurrence, so it is flagged explicitly.
    if (din == '0) nerr = NW'(WORDWIDTH);
  end

  always_comb begin
    check        = din_valid & hist_valid;
    bad          = (nerr != '0);
    state_nxt    = state;
    good_run_nxt = good_run;
    bad_run_nxt  = bad_run;
    if (check) begin
      case (state)
        HUNT: begin
          if (bad) begin
            good_run_nxt = '0;
          end else begin
            good_run_nxt = good_run + GW'(1);
            if (good_run_nxt == GW'(LOCK_GOOD)) begin
              state_nxt   = LOCKED;
              bad_run_nxt = '0;
            end
          end
        end
        LOCKED: begin
          if (!bad) begin
            bad_run_nxt = '0;
          end else begin
            bad_run_nxt = bad_run + BW'(1);
            if (bad_run_nxt == BW'(UNLOCK_BAD)) begin
              state_nxt    = HUNT;
              good_run_nxt = '0;
            end
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  always_comb begin
    sum     = SW'(errorCount) + SW'(nerr);
    cnt_nxt = errorCount;
    if (check && state == LOCKED) begin
      if (sum > SW'({CNT_WIDTH{1'b1}})) cnt_nxt = '1;
      else                              cnt_nxt = sum[CNT_WIDTH-1:0];
    end
    if (clear) cnt_nxt = '0;
    err_nxt = check & bad & ~clear;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= HUNT;
      hist7      <= '0;
      hist_valid <= 1'b0;
      good_run   <= '0;
      bad_run    <= '0;
      err        <= 1'b0;
      errorCount <= '0;
    end else begin
      state      <= state_nxt;
      good_run   <= good_run_nxt;
      bad_run    <= bad_run_nxt;
      err        <= err_nxt;
      errorCount <= cnt_nxt;
      if (din_valid) begin
        hist7      <= din[WORDWIDTH-1:WORDWIDTH-7];
        hist_valid <= 1'b1;
      end
    end
  end

  always_comb locked = (state == LOCKED);

endmodule
